uart_csr_master: RTL and testbench



---
 rtl/uart_csr_master.sv | 166 ++++++++++++++++
 tb/tb_uart_csr_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_csr_master.sv
// CSR bus initiator that drives the UART in place of the CPU: polls STATUS, drains a
// small transmit FIFO into TXDATA and captures RXDATA bytes into a one-byte holding register.
module uart_csr_master #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 3,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR  = ADDR_WIDTH'(0),
    parameter logic [ADDR_WIDTH-1:0] TXDATA_ADDR  = ADDR_WIDTH'(1),
    parameter logic [ADDR_WIDTH-1:0] RXDATA_ADDR  = ADDR_WIDTH'(2),
    parameter int unsigned           TX_BUSY_BIT  = 0,
    parameter int unsigned           RX_AVAIL_BIT = 1,
    parameter int unsigned           TX_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] csr_wr_addr,
    output logic [DATA_WIDTH-1:0] csr_wr_data,
    output logic                  csr_wen,
    output logic [ADDR_WIDTH-1:0] csr_rd_addr,
    output logic                  csr_ren,
    input  logic [DATA_WIDTH-1:0] csr_rd_data
);

    localparam int unsigned      PTR_W    = $clog2(TX_DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TX_DEPTH);

    typedef enum logic [2:0] {POLL, STAT, TXWR, RXRD, RXCAP} state_t;

    state_t                state;
    state_t                state_nxt;

    logic [7:0]            fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;

    logic                  csr_ren_nxt;
    logic                  csr_wen_nxt;
    logic [ADDR_WIDTH-1:0] csr_rd_addr_nxt;
    logic [ADDR_WIDTH-1:0] csr_wr_addr_nxt;
    logic [DATA_WIDTH-1:0] csr_wr_data_nxt;
    logic                  status_rx_avail;
    logic                  status_tx_busy;
    logic                  unused_rd_data;

    assign push            = tx_valid && tx_ready;
    assign pop             = (state == TXWR);
    assign fifo_empty      = (count == '0);
    assign count_nxt       = count + CNT_W'(push) - CNT_W'(pop);
    assign status_rx_avail = csr_rd_data[RX_AVAIL_BIT];
    assign status_tx_busy  = csr_rd_data[TX_BUSY_BIT];
    assign unused_rd_data  = ^csr_rd_data;

    // Transmit FIFO storage; contents need no reset since pointers and count do.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_nxt;
            tx_ready <= (count_nxt != CNT_FULL);
        end
    end

    // Next state, then the bus outputs for the state being entered (registered below).
    // POLL waits for its own strobe to be on the bus, which covers the first cycle after reset.
    always_comb begin
        state_nxt       = state;
        csr_ren_nxt     = 1'b0;
        csr_wen_nxt     = 1'b0;
        csr_rd_addr_nxt = '0;
        csr_wr_addr_nxt = '0;
        csr_wr_data_nxt = '0;

        unique case (state)
            POLL: begin
                if (csr_ren) state_nxt = STAT;
            end
            STAT: begin
                if (status_rx_avail && !rx_valid) begin
                    state_nxt = RXRD;
                end else if (!status_tx_busy && !fifo_empty) begin
                    state_nxt = TXWR;
                end else begin
                    state_nxt = POLL;
                end
            end
            RXRD:        state_nxt = RXCAP;
            RXCAP, TXWR: state_nxt = POLL;
            default:     state_nxt = POLL;
        endcase

        case (state_nxt)
            POLL: begin
                csr_ren_nxt     = 1'b1;
                csr_rd_addr_nxt = STATUS_ADDR;
            end
            RXRD: begin
                csr_ren_nxt     = 1'b1;
                csr_rd_addr_nxt = RXDATA_ADDR;
            end
            STAT, RXCAP: begin
                csr_rd_addr_nxt = csr_rd_addr;
            end
            TXWR: begin
                csr_wen_nxt     = 1'b1;
                csr_wr_addr_nxt = TXDATA_ADDR;
                csr_wr_data_nxt = DATA_WIDTH'(fifo_mem[rd_ptr]);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= POLL;
            csr_ren     <= 1'b0;
            csr_wen     <= 1'b0;
            csr_rd_addr <= '0;
            csr_wr_addr <= '0;
            csr_wr_data <= '0;
        end else begin
            state       <= state_nxt;
            csr_ren     <= csr_ren_nxt;
            csr_wen     <= csr_wen_nxt;
            csr_rd_addr <= csr_rd_addr_nxt;
            csr_wr_addr <= csr_wr_addr_nxt;
            csr_wr_data <= csr_wr_data_nxt;
        end
    end

    // Receive holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (state == RXCAP) begin
            rx_data  <= csr_rd_data[7:0];
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_csr_master.sv
// Bench for uart_csr_master: a behavioural UART answers the CSR port, a scoreboard
// holds expected TX writes and RX bytes, and a negedge monitor pops and compares them.
module tb_uart_csr_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [2:0]  csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        csr_wen;
    logic [2:0]  csr_rd_addr;
    logic        csr_ren;
    logic [31:0] csr_rd_data = 32'h0;

    uart_csr_master dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .csr_wr_addr (csr_wr_addr),
        .csr_wr_data (csr_wr_data),
        .csr_wen     (csr_wen),
        .csr_rd_addr (csr_rd_addr),
        .csr_ren     (csr_ren),
        .csr_rd_data (csr_rd_data)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         wen_cnt = 0;
    int         wen_last = 0;
    int         rxrd_cnt = 0;
    int         rxrd_last = 0;
    int         rxv_rise = 0;
    int         push_cyc = 0;
    int         wen_cyc_q[$];
    logic [7:0] tx_sb[$];
    logic [7:0] rx_sb[$];
    logic [7:0] uq[$];
    logic [7:0] exp_b;
    logic       rxv_d = 1'b0;
    logic       uart_busy = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_msg(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got=no event required=event (cycle %0d)", name, cyc);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: read data is returned the cycle after csr_ren; RXDATA reads pop the queue.
    always @(posedge clk) begin
        if (csr_ren) begin
            case (csr_rd_addr)
                3'd0:    csr_rd_data <= {30'h0, (uq.size() != 0), uart_busy};
                3'd2: begin
                    if (uq.size() != 0) csr_rd_data <= {24'h0, uq.pop_front()};
                    else                csr_rd_data <= 32'h0;
                end
                default: csr_rd_data <= 32'h0;
            endcase
        end
    end

    // Monitor: compares every TX write and RX handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_wen || csr_ren) check("strobe_exclusive", 32'(csr_wen && csr_ren), 32'd0);
            if (csr_wen) begin
                wen_cnt++;
                wen_last = cyc;
                wen_cyc_q.push_back(cyc);
                if (tx_sb.size() == 0) begin
                    fail_msg("tx_unexpected_write");
                end else begin
                    exp_b = tx_sb.pop_front();
                    check("tx_addr", 32'(csr_wr_addr), 32'd1);
                    check("tx_data", csr_wr_data, {24'h0, exp_b});
                end
            end else begin
                check("wr_idle_addr", 32'(csr_wr_addr), 32'd0);
                check("wr_idle_data", csr_wr_data, 32'd0);
            end
            if (csr_ren && csr_rd_addr == 3'd2) begin
                rxrd_cnt++;
                rxrd_last = cyc;
            end
            if (rx_valid && !rxv_d) rxv_rise = cyc;
            if (rx_valid && rx_ready) begin
                if (rx_sb.size() == 0) fail_msg("rx_unexpected_byte");
                else check("rx_data", 32'(rx_data), 32'(rx_sb.pop_front()));
            end
            rxv_d = rx_valid;
        end else begin
            rxv_d = 1'b0;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic push_byte(input logic [7:0] b);
        bit done = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (tx_ready) begin
                done     = 1'b1;
                push_cyc = cyc;
                tx_sb.push_back(b);
            end
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        if (!done) fail_msg("push_timeout");
    endtask

    task automatic wait_poll();
        bit found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            found = csr_ren && (csr_rd_addr == 3'd0);
        end
        if (!found) fail_msg("poll_timeout");
    endtask

    task automatic wait_wen(input int target);
        for (int k = 0; k < 300 && wen_cnt < target; k++) @(negedge clk);
        if (wen_cnt < target) fail_msg("wen_timeout");
    endtask

    task automatic wait_rxv();
        for (int k = 0; k < 100 && !rx_valid; k++) @(negedge clk);
        if (!rx_valid) fail_msg("rx_valid_timeout");
    endtask

    task automatic wait_rx_drained();
        for (int k = 0; k < 200 && rx_sb.size() != 0; k++) @(negedge clk);
        if (rx_sb.size() != 0) fail_msg("rx_drain_timeout");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0;
        int  nr;
        bit  found;

        // Reset values and first STATUS poll
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wen", 32'(csr_wen), 32'd0);
        check("rst_ren", 32'(csr_ren), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rd_addr", 32'(csr_rd_addr), 32'd0);
        check("rst_wr_addr", 32'(csr_wr_addr), 32'd0);
        check("rst_wr_data", csr_wr_data, 32'd0);
        sync();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("first_ren", 32'(csr_ren), 32'd1);
        check("first_ren_addr", 32'(csr_rd_addr), 32'd0);

        // Single TX: pushed during STAT, write appears three cycles later
        wait_poll();
        sync();
        n0 = wen_cnt;
        push_byte(8'hA5);
        wait_wen(n0 + 1);
        sync();
        check("tx_latency", 32'(wen_last - push_cyc), 32'd3);
        repeat (10) @(negedge clk);
        check("tx_fifo_empty", 32'(wen_cnt - n0), 32'd1);
        check("tx_ready_after", 32'(tx_ready), 32'd1);

        // TX busy: fill FIFO, fifth byte refused, drain at one write per 3 cycles
        sync();
        uart_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        @(negedge clk);
        check("full_ready", 32'(tx_ready), 32'd0);
        sync();
        tx_data  = 8'h05;
        tx_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("full_reject", 32'(tx_ready), 32'd0);
        end
        sync();
        tx_valid = 1'b0;
        wen_cyc_q.delete();
        n0 = wen_cnt;
        uart_busy = 1'b0;
        wait_wen(n0 + 4);
        if (wen_cyc_q.size() >= 4) begin
            for (int i = 0; i < 3; i++) check("tx_b2b_gap", 32'(wen_cyc_q[i+1] - wen_cyc_q[i]), 32'd3);
        end
        sync();
        push_byte(8'h05);
        wait_wen(n0 + 5);

        // RX capture with backpressure
        sync();
        rx_ready = 1'b0;
        uq.push_back(8'h3C);
        uq.push_back(8'h5D);
        rx_sb.push_back(8'h3C);
        rx_sb.push_back(8'h5D);
        wait_rxv();
        sync();
        check("rx_latency", 32'(rxv_rise - rxrd_last), 32'd2);
        check("rx_held_data", 32'(rx_data), 32'h3C);
        nr = rxrd_cnt;
        repeat (20) @(negedge clk);
        check("rx_hold_valid", 32'(rx_valid), 32'd1);
        check("rx_hold_data", 32'(rx_data), 32'h3C);
        check("rx_no_extra_read", 32'(rxrd_cnt - nr), 32'd0);
        check("rx_uart_pending", 32'(uq.size()), 32'd1);
        sync();
        rx_ready = 1'b1;
        wait_rx_drained();
        sync();
        check("rx_uart_empty", 32'(uq.size()), 32'd0);

        // Priority: RX served first, TX write exactly one RX service later
        uart_busy = 1'b1;
        push_byte(8'h77);
        repeat (6) sync();
        n0 = wen_cnt;
        nr = rxrd_cnt;
        uart_busy = 1'b0;
        uq.push_back(8'h11);
        rx_sb.push_back(8'h11);
        wait_wen(n0 + 1);
        sync();
        check("prio_rx_first", 32'(rxrd_cnt - nr), 32'd1);
        check("prio_tx_delay", 32'(wen_last - rxrd_last), 32'd4);
        wait_rx_drained();

        // Concurrent push during TXWR while full, then a random stream
        sync();
        uart_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'hF0 + 8'(i));
        n0 = wen_cnt;
        tx_data   = 8'hE0;
        tx_valid  = 1'b1;
        uart_busy = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            found = csr_wen;
        end
        if (!found) fail_msg("full_pop_timeout");
        check("pop_full_ready", 32'(tx_ready), 32'd0);
        @(negedge clk);
        check("pop_freed_ready", 32'(tx_ready), 32'd1);
        tx_sb.push_back(8'hE0);
        sync();
        tx_valid = 1'b0;
        for (int i = 0; i < 20; i++) push_byte(8'($urandom_range(0, 255)));
        for (int k = 0; k < 500 && tx_sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check("stream_all_written", 32'(tx_sb.size()), 32'd0);
        check("stream_count", 32'(wen_cnt - n0), 32'd25);

        // Asynchronous reset mid-TXWR with a held RX byte and queued TX bytes
        sync();
        rx_ready = 1'b0;
        uq.push_back(8'h99);
        wait_rxv();
        sync();
        uart_busy = 1'b1;
        push_byte(8'hB1);
        push_byte(8'hB2);
        uart_busy = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            found = csr_wen;
        end
        if (!found) fail_msg("txwr_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wen", 32'(csr_wen), 32'd0);
        check("arst_ren", 32'(csr_ren), 32'd0);
        check("arst_wr_data", csr_wr_data, 32'd0);
        check("arst_tx_ready", 32'(tx_ready), 32'd1);
        check("arst_rx_valid", 32'(rx_valid), 32'd0);
        tx_sb.delete();
        sync();
        rst_n = 1'b1;
        n0 = wen_cnt;
        @(posedge clk);
        @(negedge clk);
        check("arst_first_ren", 32'(csr_ren), 32'd1);
        check("arst_first_addr", 32'(csr_rd_addr), 32'd0);
        repeat (20) @(negedge clk);
        check("arst_no_stale_tx", 32'(wen_cnt - n0), 32'd0);
        check("arst_rx_still_clear", 32'(rx_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
